// File: rtl/fetch_stage_if.sv
// I-cache request/response channel between the fetch stage (master) and the instruction cache (slave).
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  icache_req_valid;
    logic                  icache_req_ready;
    logic [DATA_WIDTH-1:0] icache_req_addr;
    logic                  icache_resp_valid;
    logic [DATA_WIDTH-1:0] icache_resp_data;

    modport master (
        output icache_req_valid,
        output icache_req_addr,
        input  icache_req_ready,
        input  icache_resp_valid,
        input  icache_resp_data
    );

    modport slave (
        input  icache_req_valid,
        input  icache_req_addr,
        output icache_req_ready,
        output icache_resp_valid,
        output icache_resp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited I-cache requests and queues {PC, instr} pairs.
// Optional sticky misaligned-redirect detection is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  redirect_e,
    input  logic [DATA_WIDTH-1:0] target_e,
    fetch_stage_if.master         icache,
    output logic                  valid_d,
    output logic [DATA_WIDTH-1:0] PC_d,
    output logic [DATA_WIDTH-1:0] PCPlus4_d,
    output logic [DATA_WIDTH-1:0] Instr_d,
    output logic                  misalign
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] ifl_pc  [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_instr [QUEUE_DEPTH];
    logic [PW-1:0]         ifl_wr, ifl_rd, q_wr, q_rd;
    logic [CW-1:0]         ifl_cnt, q_cnt, drop_cnt;
    logic [CW-1:0]         ifl_cnt_next, drop_next, q_cnt_next;
    logic                  credit, accept, resp, keep, pop, halt;
    logic [DATA_WIDTH-1:0] target_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign target_pc = target_e;
    assign halt      = misalign_q;
    assign misalign  = misalign_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (redirect_e && (target_e[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end
`else
    logic unused_target_bits;

    assign target_pc          = {target_e[DATA_WIDTH-1:2], 2'b00};
    assign halt               = 1'b0;
    assign misalign           = 1'b0;
    assign unused_target_bits = ^target_e[1:0];
`endif

    // Every in-flight request holds a queue slot in reserve, so responses never overflow the queue.
    always_comb begin
        credit       = (({1'b0, ifl_cnt} + {1'b0, q_cnt}) < DEPTH_W);
        icache.icache_req_valid = (state != IDLE) && !redirect_e && !halt && credit;
        icache.icache_req_addr  = fetch_pc;
        accept       = icache.icache_req_valid && icache.icache_req_ready;
        resp         = icache.icache_resp_valid;
        keep         = resp && (drop_cnt == '0) && !redirect_e;
        pop          = valid_d && en;
        ifl_cnt_next = ifl_cnt + CW'(accept) - CW'(resp);
        q_cnt_next   = q_cnt + CW'(keep) - CW'(pop);
        drop_next    = drop_cnt;
        if (redirect_e) begin
            drop_next = ifl_cnt_next;
        end else if (resp && (drop_cnt != '0)) begin
            drop_next = drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            ifl_wr   <= '0;
            ifl_rd   <= '0;
            ifl_cnt  <= '0;
            drop_cnt <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            q_cnt    <= '0;
        end else begin
            if (state == IDLE) begin
                state <= RUN;
            end else begin
                state <= (drop_next != '0) ? DRAIN : RUN;
            end
            if (redirect_e) begin
                fetch_pc <= target_pc;
            end else if (accept) begin
                fetch_pc <= fetch_pc + DATA_WIDTH'(4);
            end
            if (accept) begin
                ifl_wr <= ifl_wr + PW'(1);
            end
            if (resp) begin
                ifl_rd <= ifl_rd + PW'(1);
            end
            ifl_cnt  <= ifl_cnt_next;
            drop_cnt <= drop_next;
            // A redirect squashes the whole queue, including any head being consumed this cycle.
            if (redirect_e) begin
                q_wr  <= '0;
                q_rd  <= '0;
                q_cnt <= '0;
            end else begin
                if (keep) begin
                    q_wr <= q_wr + PW'(1);
                end
                if (pop) begin
                    q_rd <= q_rd + PW'(1);
                end
                q_cnt <= q_cnt_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ifl_pc[ifl_wr] <= fetch_pc;
        end
        if (keep) begin
            q_pc[q_wr]    <= ifl_pc[ifl_rd];
            q_instr[q_wr] <= icache.icache_resp_data;
        end
    end

    always_comb begin
        valid_d   = (q_cnt != '0);
        PC_d      = valid_d ? q_pc[q_rd] : '0;
        PCPlus4_d = valid_d ? (q_pc[q_rd] + DATA_WIDTH'(4)) : '0;
        Instr_d   = valid_d ? q_instr[q_rd] : '0;
    end

    resp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
        icache.icache_resp_valid |-> (ifl_cnt != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 1-cycle in-order I-cache model, a decode-side capture queue and vector checks.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        redirect_e;
    logic [31:0] target_e;
    logic        valid_d;
    logic [31:0] PC_d;
    logic [31:0] PCPlus4_d;
    logic [31:0] Instr_d;
    logic        misalign;
    logic        resp_en;

    int checks   = 0;
    int failures = 0;

    logic [31:0] pending[$];
    int          pend_cnt;
    logic [31:0] pend_data;
    logic [31:0] del_pc[$];
    logic [31:0] del_p4[$];
    logic [31:0] del_instr[$];

    fetch_stage_if #(.DATA_WIDTH(32)) bus ();

    fetch_stage #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .redirect_e(redirect_e),
        .target_e  (target_e),
        .icache    (bus),
        .valid_d   (valid_d),
        .PC_d      (PC_d),
        .PCPlus4_d (PCPlus4_d),
        .Instr_d   (Instr_d),
        .misalign  (misalign)
    );

    typedef struct {
        logic        en;
        logic        ready;
        logic        exp_req_valid;
        logic [31:0] exp_addr;
        logic        exp_valid_d;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t t1_vecs [8];

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-order cache: an accepted request answers from the next cycle on, gated by resp_en.
    always @(posedge clk) begin
        if (!rst_n) begin
            pending.delete();
        end else begin
            if (bus.icache_resp_valid && pending.size() > 0) begin
                void'(pending.pop_front());
            end
            if (bus.icache_req_valid && bus.icache_req_ready) begin
                pending.push_back(bus.icache_req_addr);
            end
        end
        pend_cnt  <= pending.size();
        pend_data <= (pending.size() > 0) ? instr_of(pending[0]) : 32'h0;
    end

    assign bus.icache_resp_valid = resp_en && (pend_cnt > 0);
    assign bus.icache_resp_data  = pend_data;

    // Decode-side capture of every head that is consumed.
    always @(posedge clk) begin
        if (rst_n && valid_d && en) begin
            del_pc.push_back(PC_d);
            del_p4.push_back(PCPlus4_d);
            del_instr.push_back(Instr_d);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en_v, input logic ready_v, input logic resp_v,
                                 input logic redir_v, input logic [31:0] target_v);
        en                   = en_v;
        bus.icache_req_ready = ready_v;
        resp_en              = resp_v;
        redirect_e           = redir_v;
        target_e             = target_v;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req_valid", 32'(bus.icache_req_valid), 32'h0);
        checkOutput("rst_valid_d", 32'(valid_d), 32'h0);
        checkOutput("rst_pc_d", PC_d, 32'h0);
        checkOutput("rst_pcplus4_d", PCPlus4_d, 32'h0);
        checkOutput("rst_instr_d", Instr_d, 32'h0);
        checkOutput("rst_misalign", 32'(misalign), 32'h0);
        rst_n = 1'b1;
        del_pc.delete();
        del_p4.delete();
        del_instr.delete();
    endtask

    task automatic wait_delivered(input string name, input int n, input int budget);
        int cyc = 0;
        while (del_pc.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, "_delivered_in_time"}, 32'(del_pc.size() >= n), 32'h1);
    endtask

    task automatic check_delivered(input string name, input int idx, input logic [31:0] exp_pc);
        if (idx < del_pc.size()) begin
            checkOutput($sformatf("%s_pc%0d", name, idx), del_pc[idx], exp_pc);
            checkOutput($sformatf("%s_pcplus4_%0d", name, idx), del_p4[idx], exp_pc + 32'd4);
            checkOutput($sformatf("%s_instr%0d", name, idx), del_instr[idx], instr_of(exp_pc));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at time %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic any_req;
        logic any_vd;

        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        t1_vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        t1_vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        t1_vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
        t1_vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0};
        t1_vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        t1_vecs[5] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
        t1_vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
        t1_vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

        // T1: cycle-by-cycle sequential fetch with a 1-cycle cache
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            applyStimulus(t1_vecs[i].en, t1_vecs[i].ready, 1'b1, 1'b0, 32'h0);
            #1;
            checkOutput($sformatf("t1_s%0d_req_valid", i), 32'(bus.icache_req_valid), 32'(t1_vecs[i].exp_req_valid));
            if (t1_vecs[i].exp_req_valid)
                checkOutput($sformatf("t1_s%0d_addr", i), bus.icache_req_addr, t1_vecs[i].exp_addr);
            checkOutput($sformatf("t1_s%0d_valid_d", i), 32'(valid_d), 32'(t1_vecs[i].exp_valid_d));
            if (t1_vecs[i].exp_valid_d) begin
                checkOutput($sformatf("t1_s%0d_pc_d", i), PC_d, t1_vecs[i].exp_pc);
                checkOutput($sformatf("t1_s%0d_pcplus4_d", i), PCPlus4_d, t1_vecs[i].exp_pc + 32'd4);
                checkOutput($sformatf("t1_s%0d_instr_d", i), Instr_d, instr_of(t1_vecs[i].exp_pc));
            end
        end

        // T2: stall fills the queue, then release without losing or repeating PCs
        reset_dut();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("t2_full_req_valid", 32'(bus.icache_req_valid), 32'h0);
        checkOutput("t2_held_valid_d", 32'(valid_d), 32'h1);
        checkOutput("t2_held_pc_d", PC_d, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        wait_delivered("t2", 6, 60);
        for (int i = 0; i < 6; i++) check_delivered("t2", i, 32'(4 * i));

        // T3: redirect with two requests in flight drops both stale responses
        reset_dut();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t3_credit_full", 32'(bus.icache_req_valid), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("t3_addr_after_redirect", bus.icache_req_addr, 32'h100);
        checkOutput("t3_no_credit_while_stale", 32'(bus.icache_req_valid), 32'h0);
        checkOutput("t3_queue_flushed", 32'(valid_d), 32'h0);
        wait_delivered("t3", 2, 40);
        check_delivered("t3", 0, 32'h100);
        check_delivered("t3", 1, 32'h104);

        // T4: second redirect during DRAIN also drops a request issued while draining
        reset_dut();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("t4_drain_req_valid", 32'(bus.icache_req_valid), 32'h1);
        checkOutput("t4_drain_req_addr", bus.icache_req_addr, 32'h100);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        wait_delivered("t4", 2, 40);
        check_delivered("t4", 0, 32'h200);
        check_delivered("t4", 1, 32'h204);

        // T5: PC wraps past the top of the address space
        reset_dut();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        #1;
        checkOutput("t5_req_suppressed_on_redirect", 32'(bus.icache_req_valid), 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("t5_req_valid_top", 32'(bus.icache_req_valid), 32'h1);
        checkOutput("t5_req_addr_top", bus.icache_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        checkOutput("t5_req_valid_wrap", 32'(bus.icache_req_valid), 32'h1);
        checkOutput("t5_req_addr_wrap", bus.icache_req_addr, 32'h0);
        wait_delivered("t5", 2, 40);
        check_delivered("t5", 0, 32'hFFFF_FFFC);
        check_delivered("t5", 1, 32'h0);

        // T6: misaligned redirect target
        reset_dut();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h102);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("t6_misalign_set", 32'(misalign), 32'h1);
        any_req = 1'b0;
        any_vd  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            any_req = any_req | bus.icache_req_valid;
            any_vd  = any_vd | valid_d;
        end
        checkOutput("t6_no_requests_after_halt", 32'(any_req), 32'h0);
        checkOutput("t6_no_valid_after_halt", 32'(any_vd), 32'h0);
        checkOutput("t6_misalign_sticky", 32'(misalign), 32'h1);
        checkOutput("t6_nothing_delivered", 32'(del_pc.size()), 32'h0);
`else
        any_req = 1'b0;
        any_vd  = 1'b0;
        checkOutput("t6_misalign_tied_low", 32'(misalign), 32'h0);
        checkOutput("t6_target_aligned", bus.icache_req_addr, 32'h100);
        wait_delivered("t6", 1, 40);
        check_delivered("t6", 0, 32'h100);
        checkOutput("t6_misalign_still_low", 32'(misalign | any_req | any_vd), 32'h0);
`endif
        reset_dut();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
